text_scroller: RTL and testbench

- Reader side of the message character ROM: walks a 4-character window across the 12-entry message, fetches char codes over a 4-bit address/data ROM port, and decodes them.
- Time-multiplexes the decoded characters onto a 4-digit common-anode seven-segment display.
- Sits between the student message ROM (combinational, addr -> char_code) and the board display pins.

---
 rtl/text_scroller.sv | 143 ++++++++++++++
 tb/tb_text_scroller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/text_scroller.sv
// text_scroller: scrolls a 4-character window across a message ROM. The window is shown
// on a 4-digit common-anode seven-segment display that is scanned one digit at a time.
module text_scroller #(
  parameter int unsigned MSG_LEN    = 12,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned SCROLL_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  output logic [3:0] rom_addr,
  input  logic [3:0] rom_data,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic [3:0] pos
);

  localparam int unsigned ScanW   = $clog2(SCAN_DIV);
  localparam int unsigned ScrollW = $clog2(SCROLL_DIV);

  localparam logic [ScanW-1:0]   ScanLast   = ScanW'(SCAN_DIV - 1);
  localparam logic [ScrollW-1:0] ScrollLast = ScrollW'(SCROLL_DIV - 1);
  localparam logic [4:0]         MsgLen5    = 5'(MSG_LEN);
  localparam logic [3:0]         LastPos    = 4'(MSG_LEN - 1);

  logic [ScanW-1:0]   scan_cnt_q, scan_cnt_d;
  logic [ScrollW-1:0] scroll_cnt_q, scroll_cnt_d;
  logic [3:0]         pos_q, pos_d;
  logic [1:0]         slot_q, slot_d;
  logic [3:0]         rom_addr_q, rom_addr_d;
  logic [3:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               pend_q, pend_d;  // second pipeline stage due next cycle

  logic       scan_tick;
  logic       scroll_tick;
  logic [1:0] slot_next;
  logic [4:0] addr_sum;
  logic [4:0] addr_wrap;

  // Char code to active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    unique case (code)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h06;  // E
      4'hB: s = 7'h47;  // L
      4'hC: s = 7'h46;  // C
      4'hD: s = 7'h0C;  // P
      4'hE: s = 7'h12;  // S
      4'hF: s = 7'h3F;  // dash
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign scan_tick   = (scan_cnt_q == ScanLast);
  assign scroll_tick = en && (scroll_cnt_q == ScrollLast);

  // Window address for the slot about to be shown, wrapped into 0..MSG_LEN-1.
  assign slot_next = slot_q + 2'd1;
  assign addr_sum  = {1'b0, pos_q} + {3'b000, slot_next};
  assign addr_wrap = (addr_sum >= MsgLen5) ? addr_sum - MsgLen5 : addr_sum;

  // Prescalers: scan runs free, scroll holds its phase while disabled.
  always_comb begin
    scan_cnt_d   = scan_tick ? '0 : scan_cnt_q + ScanW'(1);
    scroll_cnt_d = scroll_cnt_q;
    if (en) begin
      scroll_cnt_d = (scroll_cnt_q == ScrollLast) ? '0 : scroll_cnt_q + ScrollW'(1);
    end
  end

  // Window start position, stepping with wrap in the selected direction.
  always_comb begin
    pos_d = pos_q;
    if (scroll_tick) begin
      if (dir) begin
        pos_d = (pos_q == 4'd0) ? LastPos : pos_q - 4'd1;
      end else begin
        pos_d = (pos_q == LastPos) ? 4'd0 : pos_q + 4'd1;
      end
    end
  end

  // Scan pipeline: blank and fetch on the tick, light the digit one cycle later.
  always_comb begin
    slot_d     = slot_q;
    rom_addr_d = rom_addr_q;
    an_d       = an_q;
    seg_d      = seg_q;
    pend_d     = 1'b0;
    if (pend_q) begin
      seg_d = decode(rom_data);
      an_d  = ~(4'b1000 >> slot_q);
    end
    if (scan_tick) begin
      slot_d     = slot_next;
      rom_addr_d = addr_wrap[3:0];
      an_d       = 4'hF;
      pend_d     = 1'b1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q   <= '0;
      scroll_cnt_q <= '0;
      pos_q        <= 4'd0;
      slot_q       <= 2'd0;
      rom_addr_q   <= 4'd0;
      an_q         <= 4'hF;
      seg_q        <= 7'h7F;
      pend_q       <= 1'b0;
    end else begin
      scan_cnt_q   <= scan_cnt_d;
      scroll_cnt_q <= scroll_cnt_d;
      pos_q        <= pos_d;
      slot_q       <= slot_d;
      rom_addr_q   <= rom_addr_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      pend_q       <= pend_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign an       = an_q;
  assign seg      = seg_q;
  assign pos      = pos_q;

endmodule

// File: tb/tb_text_scroller.sv
// Bench for text_scroller: randomized en/dir stimulus against a behavioural model, plus
// directed checks of first display, frame contents, wrap, re-enable phase and async reset.
module tb_text_scroller;

  localparam int MSG_LEN    = 12;
  localparam int SCAN_DIV   = 4;
  localparam int SCROLL_DIV = 64;

  logic       clk;
  logic       rst;
  logic       en;
  logic       dir;
  logic [3:0] rom_addr;
  logic [3:0] rom_data;
  logic [3:0] an;
  logic [6:0] seg;
  logic [3:0] pos;

  logic [3:0] rom_mem [16];
  logic [6:0] dec_tab [16];
  logic [6:0] cap     [4];

  int n_tests;
  int n_fail;

  // Behavioural model state.
  int m_scan, m_scroll, m_pos, m_slot, m_addr, m_an, m_seg;
  bit m_pend;

  text_scroller #(
    .MSG_LEN   (MSG_LEN),
    .SCAN_DIV  (SCAN_DIV),
    .SCROLL_DIV(SCROLL_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .dir     (dir),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .an      (an),
    .seg     (seg),
    .pos     (pos)
  );

  assign rom_data = rom_mem[rom_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_scan = 0; m_scroll = 0; m_pos = 0; m_slot = 0; m_addr = 0;
    m_an = 'hF; m_seg = 'h7F; m_pend = 0;
  endtask

  // One clock of the spec's behaviour, using the inputs present at the edge.
  task automatic model_step();
    bit tick, stick;
    tick  = (m_scan == SCAN_DIV - 1);
    stick = en && (m_scroll == SCROLL_DIV - 1);
    if (m_pend) begin
      m_seg  = dec_tab[rom_mem[m_addr]];
      m_an   = 'hF - (1 << (3 - m_slot));
      m_pend = 0;
    end
    if (tick) begin
      m_slot = (m_slot + 1) % 4;
      m_addr = (m_pos + m_slot) % MSG_LEN;
      m_an   = 'hF;
      m_pend = 1;
    end
    if (stick) m_pos = dir ? (m_pos + MSG_LEN - 1) % MSG_LEN : (m_pos + 1) % MSG_LEN;
    m_scan = (m_scan + 1) % SCAN_DIV;
    if (en) m_scroll = (m_scroll + 1) % SCROLL_DIV;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    check("an", int'(an), m_an);
    check("seg", int'(seg), m_seg);
    check("pos", int'(pos), m_pos);
    check("rom_addr", int'(rom_addr), m_addr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  // Run one full frame and record the segments shown in each digit position.
  task automatic capture_frame();
    for (int k = 0; k < 4; k++) cap[k] = 7'h7F;
    repeat (4 * SCAN_DIV + 2) begin
      cycle();
      case (an)
        4'b0111: cap[0] = seg;
        4'b1011: cap[1] = seg;
        4'b1101: cap[2] = seg;
        4'b1110: cap[3] = seg;
        default: ;
      endcase
    end
  endtask

  task automatic check_frame(input string tag, input int s0, input int s1, input int s2,
                             input int s3);
    check({tag, "_d0"}, int'(cap[0]), s0);
    check({tag, "_d1"}, int'(cap[1]), s1);
    check({tag, "_d2"}, int'(cap[2]), s2);
    check({tag, "_d3"}, int'(cap[3]), s3);
  endtask

  initial begin
    int n, p0;
    bit seen;
    n_tests = 0;
    n_fail  = 0;
    // "SP24-ELC-068": E=A L=B C=C P=D S=E dash=F
    rom_mem = '{4'hE, 4'hD, 4'h2, 4'h4, 4'hF, 4'hA, 4'hB, 4'hC,
                4'hF, 4'h0, 4'h6, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
    dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h06, 7'h47, 7'h46, 7'h0C, 7'h12, 7'h3F};
    rst = 1'b1;
    en  = 1'b0;
    dir = 1'b0;
    model_reset();

    // Reset state and first lit digit.
    do_reset();
    check("rst_an", int'(an), 'hF);
    check("rst_seg", int'(seg), 'h7F);
    check("rst_pos", int'(pos), 0);
    check("rst_addr", int'(rom_addr), 0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      if (an != 4'hF) seen = 1;
    end
    check("first_lit_seen", int'(seen), 1);
    check("first_lit_an", int'(an), 'b1011);
    check("first_lit_addr", int'(rom_addr), 1);
    check("first_lit_seg", int'(seg), 'h0C);

    // Frozen window over 16 scan slots.
    repeat (16 * SCAN_DIV) cycle();
    check("frozen_pos", int'(pos), 0);
    capture_frame();
    check_frame("frame0", 'h12, 'h0C, 'h24, 'h19);

    // Nine left steps wrap the window past the end of the message.
    en = 1'b1; dir = 1'b0;
    do_reset();
    repeat (9 * SCROLL_DIV) cycle();
    check("left9_pos", int'(pos), 9);
    en = 1'b0;
    capture_frame();
    check_frame("frame9", 'h40, 'h02, 'h00, 'h12);

    // One right step from reset wraps to the last index.
    en = 1'b1; dir = 1'b1;
    do_reset();
    repeat (SCROLL_DIV) cycle();
    check("right1_pos", int'(pos), 11);
    en = 1'b0;
    capture_frame();
    check_frame("frame11", 'h00, 'h12, 'h0C, 'h24);

    // Pausing at scroll_cnt = 30 resumes the phase rather than restarting it.
    en = 1'b1; dir = 1'b0;
    do_reset();
    repeat (30) cycle();
    en = 1'b0;
    repeat (100) cycle();
    en = 1'b1;
    p0 = int'(pos);
    n  = 0;
    seen = 0;
    while (n < 80 && !seen) begin
      cycle();
      n++;
      if (int'(pos) != p0) seen = 1;
    end
    check("reen_latency", n, 34);
    check("reen_step", int'(pos), (p0 + 1) % MSG_LEN);

    // Randomized en/dir against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) en = ~en;
      if ($urandom_range(0, 31) == 0) dir = $urandom_range(0, 1) == 1;
      cycle();
    end

    // Asynchronous reset pulse while a digit is lit.
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      if (an != 4'hF) seen = 1;
    end
    check("async_lit_seen", int'(seen), 1);
    #1 rst = 1'b1;
    #1;
    check("async_an", int'(an), 'hF);
    check("async_seg", int'(seg), 'h7F);
    check("async_pos", int'(pos), 0);
    check("async_addr", int'(rom_addr), 0);
    #2 rst = 1'b0;
    model_reset();
    en = 1'b1;
    repeat (3 * SCROLL_DIV) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
